bram_port_arbiter: RTL
======================

# bram_port_arbiter

Two-port arbiter that shares the single-port feature/weight BRAM between the UART host command path and the CNN accelerator engine. It sits between the two requesters and the BRAM primitive. Each cycle it grants at most one access, using round-robin selection with bounded bursts, and routes one-cycle-latency read data back to the requester that issued the read.

## Interface
- ADDR_W, 8, BRAM address width
- DATA_W, 8, BRAM data width
- MAX_BURST, 16, max consecutive beats granted to one owner while the other requests (≥1)
- clk  in  1  system clock; everything is synchronous to its rising edge
- reset  in  1  asynchronous, active-high reset
- h_req  in  1  host access request; held with h_we/h_addr/h_wdata stable until h_gnt
- h_we  in  1  host write enable (1 = write, 0 = read)
- h_addr  in  ADDR_W  host address
- h_wdata  in  DATA_W  host write data
- h_gnt  out  1  host access accepted this cycle
- h_rvalid  out  1  host read data valid
- h_rdata  out  DATA_W  host read data
- a_req, a_we, a_addr, a_wdata, a_gnt, a_rvalid, a_rdata: accelerator port, identical semantics to the h_* signals
- bram_en  out  1  BRAM enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  ADDR_W  BRAM address
- bram_wdata  out  DATA_W  BRAM write data
- bram_rdata  in  DATA_W  BRAM read data, registered inside the BRAM, valid 1 cycle after an enabled read

## Operation
- Registered state:
  - owner: IDLE / HOST / ACC.
  - last: the most recently served port. Reset value is ACC, so the host wins the first tie.
  - beat counter, width $clog2(MAX_BURST+1).
  - rd_pend and rd_tag.
- Grant logic is combinational from the registered state and the current requests. Exactly one of h_gnt/a_gnt can be 1 in a cycle.
- owner IDLE:
  - A single requester is granted.
  - If both request, the port that is not `last` is granted.
- owner X, X still requesting:
  - X is granted while count < MAX_BURST.
  - When count == MAX_BURST and the other port requests, the other port is granted this cycle. Ownership switches and count = 1.
  - When count == MAX_BURST and the other port is idle, X keeps the grant and count restarts at 1.
- owner X, X drops its request: the other port is granted this cycle if it requests; otherwise owner → IDLE.
- On every grant: owner ← granted port, last ← granted port, count ← count+1 (or 1 on a switch).
- When neither port is granted, count ← 0 and owner ← IDLE.
- BRAM drive:
  - bram_en = h_gnt | a_gnt.
  - bram_we/addr/wdata are muxed from the granted port.
  - With no grant, bram_we=0 and addr/wdata=0.
- Reads: a granted read sets rd_pend=1 and rd_tag=port for the next cycle. In that cycle the tagged port's rvalid=1.
- h_rdata and a_rdata both carry bram_rdata directly. They are meaningful only while the corresponding rvalid is high.
- Writes produce no rvalid.

## Timing
- Access accepted in cycle N (req & gnt):
  - BRAM sees the access in cycle N.
  - For a read, rvalid is high in cycle N+1 only.
- Back-to-back beats are allowed, one per cycle. A read in N and a read in N+1 give rvalid in N+1 and N+2.
- Owner switch costs no idle cycle.
- Write/read to the same address in consecutive cycles: the read returns the newly written data (BRAM write-first).
- Reset (any time, including mid-burst or with a read pending):
  - owner=IDLE, last=ACC, count=0, rd_pend=0.
  - All gnt, rvalid and bram_en/bram_we are 0 while reset is high.
  - A pending rvalid is dropped, not delivered.
- Requester changing addr/we while req=1 and gnt=0 is a protocol violation; behaviour is undefined.

## Test plan
- Reset then idle: all outputs 0. Host read of addr 0x0A after a prior write of 0x55: h_gnt same cycle, h_rvalid=1 with h_rdata=0x55 exactly one cycle later, a_rvalid stays 0.
- Simultaneous first requests from both ports: host granted first (last=ACC at reset), then accelerator on the next cycle. Alternation continues for single-beat requests.
- Accelerator holds a_req for 40 beats while the host requests continuously, MAX_BURST=16: grant pattern is 16 ACC, 1+ HOST per host burst, 16 ACC…, with no cycle where bram_en=0 while any req is high.
- Accelerator streams writes 0x00..0x0F to addresses 0x00..0x0F, then the host reads all 16: each h_rdata equals its address, every read is tagged to the host only, and no a_rvalid is seen.
- Reset asserted the cycle after a granted read: no rvalid on either port. After release, first grant goes to the host on a tie and count restarts.
- Host read and accelerator write to the same address in adjacent cycles (write first): host reads back the written value.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one single-port BRAM between the UART host path
// and the CNN accelerator. Round-robin on ties, bounded bursts while the other
// side waits, and one-cycle read data routed back to whoever issued the read.
module bram_port_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  // host command path
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  // accelerator engine
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  // BRAM primitive
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] OWN_IDLE = 2'd0;
  localparam logic [1:0] OWN_HOST = 2'd1;
  localparam logic [1:0] OWN_ACC  = 2'd2;

  // Port index: 0 = host, 1 = accelerator
  localparam logic PORT_HOST = 1'b0;
  localparam logic PORT_ACC  = 1'b1;

  logic [1:0]       owner_reg, owner_next;
  logic             last_reg, last_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             rd_pend_reg, rd_tag_reg;

  logic             gnt_any;
  logic             gnt_port;
  logic             gnt_live;
  logic             cur_port;
  logic             cur_req;
  logic             oth_req;
  logic             sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]       gnt_vec;
  logic [1:0]       rvalid_vec;

  // Pick at most one port this cycle from the owner/last/count state and live requests
  always_comb begin
    gnt_any  = 1'b0;
    gnt_port = PORT_HOST;
    cur_port = (owner_reg == OWN_ACC);
    cur_req  = cur_port ? a_req : h_req;
    oth_req  = cur_port ? h_req : a_req;
    if (owner_reg == OWN_IDLE) begin
      if (h_req && a_req) begin
        gnt_any  = 1'b1;
        gnt_port = ~last_reg;
      end else if (h_req || a_req) begin
        gnt_any  = 1'b1;
        gnt_port = a_req;
      end
    end else if (cur_req) begin
      // Owner keeps going until its burst is used up; only a waiting peer can take over
      gnt_any  = 1'b1;
      gnt_port = (count_reg == CNT_MAX && oth_req) ? ~cur_port : cur_port;
    end else if (oth_req) begin
      gnt_any  = 1'b1;
      gnt_port = ~cur_port;
    end
  end

  // Next owner/last/burst count; a burst that hits the limit with no contender restarts at 1
  always_comb begin
    owner_next = OWN_IDLE;
    last_next  = last_reg;
    count_next = '0;
    if (gnt_any) begin
      owner_next = gnt_port ? OWN_ACC : OWN_HOST;
      last_next  = gnt_port;
      if (owner_reg != OWN_IDLE && gnt_port == cur_port && count_reg != CNT_MAX)
        count_next = count_reg + 1'b1;
      else
        count_next = CNT_ONE;
    end
  end

  // Arbitration state and the read-return tag for the following cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_reg   <= OWN_IDLE;
      last_reg    <= PORT_ACC;
      count_reg   <= '0;
      rd_pend_reg <= 1'b0;
      rd_tag_reg  <= PORT_HOST;
    end else begin
      owner_reg   <= owner_next;
      last_reg    <= last_next;
      count_reg   <= count_next;
      rd_pend_reg <= gnt_any & ~sel_we;
      rd_tag_reg  <= gnt_port;
    end
  end

  // Reset forces the combinational grant low even though the requests may still be high
  assign gnt_live  = gnt_any & ~reset;

  assign sel_we    = gnt_port ? a_we    : h_we;
  assign sel_addr  = gnt_port ? a_addr  : h_addr;
  assign sel_wdata = gnt_port ? a_wdata : h_wdata;

  assign bram_en    = gnt_live;
  assign bram_we    = gnt_live & sel_we;
  assign bram_addr  = gnt_live ? sel_addr  : '0;
  assign bram_wdata = gnt_live ? sel_wdata : '0;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign gnt_vec[gi]    = gnt_live && (gnt_port == 1'(gi));
      assign rvalid_vec[gi] = rd_pend_reg && (rd_tag_reg == 1'(gi));
    end
  endgenerate

  assign h_gnt    = gnt_vec[0];
  assign a_gnt    = gnt_vec[1];
  assign h_rvalid = rvalid_vec[0];
  assign a_rvalid = rvalid_vec[1];

  // Read data goes to both ports unqualified; rvalid tells each side whether it is theirs
  assign h_rdata = bram_rdata;
  assign a_rdata = bram_rdata;

endmodule
